ifu_fetch_ctrl: RTL

Multi-cycle instruction fetch stage that sits directly upstream of the instruction decode unit and replaces the combinational fetch of the single-cycle core.
- Owns the architectural PC.
- Issues fetch requests to instruction memory over a valid/ready request channel and captures the response.
- Presents {pc, inst} to decode with a valid/ready handshake.
- Advances only when execute commits a next_pc, so exactly one instruction is in flight.

---
 rtl/ifu_pkg.sv | 16 +
 rtl/ifu_fetch_ctrl.sv | 100 ++++++++++
 2 files changed

// File: rtl/ifu_pkg.sv
// Shared types and constants for the instruction fetch unit.
package ifu_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_REQ,
    S_WAIT,
    S_VALID,
    S_EXEC
  } state_t;

  localparam logic [63:0] RESET_PC_DEF = 64'h8000_0000;
  localparam logic [31:0] INST_NOP     = 32'h0000_0013;
  localparam logic [31:0] EBREAK       = 32'h0010_0073;

endpackage

// File: rtl/ifu_fetch_ctrl.sv
// Multi-cycle fetch: one instruction in flight, 5 cycles best case (IDLE/REQ/WAIT/VALID/EXEC).
// Stalls in REQ on imem_req_ready, in VALID on inst_ready, and in EXEC until commit_valid.
module ifu_fetch_ctrl
  import ifu_pkg::*;
#(
  parameter int                    PC_WIDTH   = 64,
  parameter int                    INST_WIDTH = 32,
  parameter logic [PC_WIDTH-1:0]   RESET_PC   = RESET_PC_DEF[PC_WIDTH-1:0]
) (
  input  logic                  clk,
  input  logic                  rst,
  output logic                  imem_req_valid,
  input  logic                  imem_req_ready,
  output logic [PC_WIDTH-1:0]   imem_req_addr,
  input  logic                  imem_rsp_valid,
  input  logic [INST_WIDTH-1:0] imem_rsp_data,
  input  logic                  imem_rsp_err,
  output logic                  inst_valid,
  input  logic                  inst_ready,
  output logic [INST_WIDTH-1:0] inst,
  output logic [PC_WIDTH-1:0]   pc,
  output logic                  fetch_err,
  input  logic                  commit_valid,
  input  logic [PC_WIDTH-1:0]   next_pc,
  output logic [63:0]           retired_cnt
);

  state_t                state_q, state_d;
  logic [PC_WIDTH-1:0]   pc_q, pc_d;
  logic [INST_WIDTH-1:0] inst_q, inst_d;
  logic                  err_q, err_d;
  logic [63:0]           retired_q, retired_d;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= S_IDLE;
      pc_q      <= RESET_PC;
      inst_q    <= '0;
      err_q     <= 1'b0;
      retired_q <= '0;
    end else begin
      state_q   <= state_d;
      pc_q      <= pc_d;
      inst_q    <= inst_d;
      err_q     <= err_d;
      retired_q <= retired_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    pc_d      = pc_q;
    inst_d    = inst_q;
    err_d     = err_q;
    retired_d = retired_q;
    unique case (state_q)
      // A misaligned PC never reaches memory; it is reported to decode as a faulting slot.
      S_IDLE: begin
        if (pc_q[1:0] != 2'b00) begin
          state_d = S_VALID;
          err_d   = 1'b1;
          inst_d  = '0;
        end else begin
          state_d = S_REQ;
        end
      end
      S_REQ: begin
        if (imem_req_ready) state_d = S_WAIT;
      end
      S_WAIT: begin
        if (imem_rsp_valid) begin
          inst_d  = imem_rsp_data;
          err_d   = imem_rsp_err;
          state_d = S_VALID;
        end
      end
      S_VALID: begin
        if (inst_ready) state_d = S_EXEC;
      end
      S_EXEC: begin
        if (commit_valid) begin
          pc_d      = next_pc;
          retired_d = retired_q + 64'd1;
          state_d   = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // All outputs are registers or state decodes, so no input reaches an output combinationally.
  assign imem_req_valid = (state_q == S_REQ);
  assign imem_req_addr  = pc_q;
  assign inst_valid     = (state_q == S_VALID);
  assign inst           = inst_q;
  assign pc             = pc_q;
  assign fetch_err      = err_q;
  assign retired_cnt    = retired_q;

endmodule
